ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Write-side counterpart to the fetch path: takes a byte stream with a valid/ready handshake and turns it into RAM write cycles (`we`/`a`/`x`) so a program image can be placed in RAM before or between runs.
- A frame is: header byte, load address, length, payload bytes.
- The block owns the write port of the RAM while `busy`; the fetch side must not write during that time.

Parameters:
- DW, 8, data width in bits; the stream byte width and the RAM word width.
- AW, 20, RAM address width in bits.
- HDR, 8'hA5, frame start byte.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  stream byte is valid.
- in_data  input  DW  stream byte.
- in_ready  output  1  block accepts `in_data` this cycle.
- we  output  1  RAM write enable, one-cycle pulse per payload byte.
- a  output  AW  RAM write address.
- x  output  DW  RAM write data.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse: frame completed successfully.
- err  output  1  one-cycle pulse: frame aborted.

Behaviour:
- Interface: one clock (`clk`); reset `rst` is synchronous and active-high. `rst`=1 at a posedge forces the following on the next cycle, including mid-frame: state=IDLE; `we`=0, `a`=0, `x`=0, `done`=0, `err`=0, `busy`=0; `in_ready`=1; internal address, length and sum are cleared.
- Handshake: a byte is accepted on a posedge where `in_valid`&&`in_ready`. `in_ready` is 1 in every state except DONE/ERR, so sustained throughput is 1 byte/cycle.
- States:
  - IDLE: accepted byte == HDR -> A0. Any other byte is dropped; stay in IDLE; no `err`.
  - A0, A1, A2: address, little-endian, 3 bytes. A2 bits [7:AW-16] must be 0 (for AW=20, upper nibble). Nonzero -> ERR.
  - L0, L1: 16-bit length N, little-endian. At L1 accept: N==0 -> DONE (or CSUM if enabled); else -> DATA.
  - DATA: each accepted byte schedules a write. Next cycle: `we`=1, `a`=current address, `x`=byte. The address then increments modulo 2^AW (wrap 2^AW-1 -> 0 is legal and silent), and the remaining count decrements. After the N-th byte is accepted -> DONE (or CSUM).
  - DONE: `done`=1 for exactly one cycle, `in_ready`=0 -> IDLE. The final `we` pulse and `done` occur in the same cycle.
  - ERR: `err`=1 for exactly one cycle, `in_ready`=0 -> IDLE. No further writes.
- Latency: payload byte accepted at cycle t -> write visible at cycle t+1. `we`=0 in all other cycles.
- `a` and `x` hold their last values while `we`=0.
- `busy`=1 from the cycle after HDR is accepted through the DONE/ERR cycle, inclusive.
- `in_valid` low at any point: hold state; no timeout.

Optional Feature:
- Macro: RAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte (or after L1 when N==0), state CSUM accepts one checksum byte.
  - Sum = 8-bit modulo sum of all bytes after HDR: A0..A2, L0, L1, payload, checksum.
  - Sum==0 -> DONE; else -> ERR.
  - Payload writes already issued are not undone.
- Undefined: no CSUM state; the sum logic is not generated; transitions go directly to DONE as described above.

Test Plan:
- Basic: stream A5,00,10,00,03,00,11,22,33 back-to-back -> `we` pulses at a=0x01000,0x01001,0x01002 with x=11,22,33; `done` on the cycle of the third `we`; `busy` low the cycle after.
- Noise and backpressure: bytes 00,FF then the basic frame, with `in_valid` deasserted every other cycle -> 00 and FF dropped, no `err`; same three writes, each one cycle after its acceptance.
- Wrap: address FF,FF,0F, N=2, payload AA,BB -> writes at 0xFFFFF (AA) then 0x00000 (BB); then `done`.
- Bad address / zero length: A2=0x1F -> `err` pulse, no `we`, back to IDLE. N=0 frame -> `done` with no `we`.
- Reset mid-frame: assert `rst` after the second payload byte of an N=4 frame -> next cycle IDLE, `we`=0, `a`=0, no `done`. A following fresh frame loads correctly.
- Checksum (RAM_LOADER_CHECKSUM_EN): frame A5,00,00,00,01,00,05 + csum FA -> `done`. Same frame with csum FB -> write at 0x00000 (x=05) still occurs, then `err` pulse.

Source files
------------

// File: rtl/ram_loader.sv
// Stream-to-RAM frame loader: HDR, 3-byte address, 2-byte length, payload -> RAM write pulses.
// Optional trailing checksum byte when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader #(
  parameter int            DW  = 8,
  parameter int            AW  = 20,
  parameter logic [DW-1:0] HDR = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] a,
  output logic [DW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    dbg_state
);

  // Handshake: a byte moves on a posedge where in_valid && in_ready; in_ready is
  // registered and drops only for the single DONE/ERR cycle.
  typedef enum logic [3:0] {
    S_IDLE, S_A0, S_A1, S_A2, S_L0, S_L1, S_DATA,
`ifdef RAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

`ifdef RAM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  // Bits of the top address byte that lie above the RAM address range.
  localparam logic [7:0] A2_MASK = 8'hFF << (AW - 16);

  state_t        state, nxt;
  logic          acc;
  logic [AW-1:0] addr;
  logic [15:0]   len;
  logic [15:0]   n_len;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign acc       = in_valid && in_ready;
  assign n_len     = {in_data[7:0], len[7:0]};
  assign dbg_state = state;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (acc && in_data == HDR) nxt = S_A0;
      S_A0:   if (acc) nxt = S_A1;
      S_A1:   if (acc) nxt = S_A2;
      S_A2:   if (acc) nxt = ((in_data[7:0] & A2_MASK) != 8'd0) ? S_ERR : S_L0;
      S_L0:   if (acc) nxt = S_L1;
      S_L1:   if (acc) nxt = (n_len == 16'd0) ? S_FIN : S_DATA;
      S_DATA: if (acc && len == 16'd1) nxt = S_FIN;
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CSUM: if (acc) nxt = (8'(sum + in_data[7:0]) == 8'd0) ? S_DONE : S_ERR;
`endif
      S_DONE: nxt = S_IDLE;
      S_ERR:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      we       <= 1'b0;
      a        <= '0;
      x        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
      addr     <= '0;
      len      <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= nxt;
      busy     <= (nxt != S_IDLE);
      in_ready <= !(nxt == S_DONE || nxt == S_ERR);
      done     <= (nxt == S_DONE);
      err      <= (nxt == S_ERR);
      we       <= 1'b0;
      if (acc) begin
        case (state)
          S_A0: addr[7:0]     <= in_data[7:0];
          S_A1: addr[15:8]    <= in_data[7:0];
          S_A2: addr[AW-1:16] <= in_data[AW-17:0];
          S_L0: len[7:0]      <= in_data[7:0];
          S_L1: len           <= n_len;
          S_DATA: begin
            we   <= 1'b1;
            a    <= addr;
            x    <= in_data;
            addr <= addr + AW'(1);
            len  <= len - 16'd1;
          end
          default: ;
        endcase
      end
      if (nxt == S_IDLE) begin
        addr <= '0;
        len  <= '0;
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      // Running sum covers every byte after HDR, including the checksum itself.
      if (nxt == S_IDLE) sum <= '0;
      else if (acc && state != S_IDLE) sum <= sum + in_data[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: frame-level reference model checked every cycle, plus
// directed frames whose RAM writes are pinned against literal expectations.
module tb_ram_loader;
  localparam int         DW  = 8;
  localparam int         AW  = 20;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, we, busy, done, err;
  logic [AW-1:0] a;
  logic [DW-1:0] x;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  ram_loader #(.DW(DW), .AW(AW), .HDR(HDR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .a(a), .x(x),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic          m_we = 1'b0, m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_ready = 1'b1;
  logic [AW-1:0] m_a = '0;
  logic [7:0]    m_x = '0;
  logic [7:0]    fb[$];

  always @(posedge clk) begin : model
    int k, n, s;
    logic [23:0] base;
    bit acc;
    if (rst) begin
      m_we = 0; m_done = 0; m_err = 0; m_busy = 0; m_ready = 1;
      m_a = '0; m_x = '0;
      fb.delete();
    end else begin
      acc = in_valid && m_ready;
      m_we = 0; m_done = 0; m_err = 0;
      if (acc) begin
        if (fb.size() == 0) begin
          if (in_data == HDR) fb.push_back(in_data);
        end else begin
          fb.push_back(in_data);
          k = fb.size() - 1;
          if (k == 3 && (in_data >> (AW - 16)) != 8'd0) begin
            m_err = 1;
            fb.delete();
          end else if (k >= 5) begin
            n    = int'({fb[5], fb[4]});
            base = {fb[3], fb[2], fb[1]};
            if (k >= 6 && k < 6 + n) begin
              m_we = 1;
              m_a  = AW'(int'(base) + k - 6);
              m_x  = in_data;
            end
            if (k == 5 + n + CS) begin
              s = 0;
              for (int i = 1; i <= k; i++) s += int'(fb[i]);
              if (CS == 0 || (s % 256) == 0) m_done = 1;
              else m_err = 1;
              fb.delete();
            end
          end
        end
      end
      m_busy  = (fb.size() > 0) || m_done || m_err;
      m_ready = !(m_done || m_err);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", 32'(we), 32'(m_we));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("a", 32'(a), 32'(m_a));
      chk("x", 32'(x), 32'(m_x));
    end
  end

  // ---------------- scoreboard of observed writes ----------------
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  int obs_done = 0;
  int obs_err  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (we === 1'b1) obs_q.push_back({a, x});
      if (done === 1'b1) obs_done++;
      if (err === 1'b1) obs_err++;
    end
  end

  task automatic check_obs(input string nm, input int dn, input int er);
    chk({nm, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) chk({nm, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
      else chk({nm, "_wr_missing"}, 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    chk({nm, "_done"}, 32'(obs_done), 32'(dn));
    chk({nm, "_err"}, 32'(obs_err), 32'(er));
    exp_q.delete(); obs_q.delete(); obs_done = 0; obs_err = 0;
  endtask

  // ---------------- driver ----------------
  logic [7:0] tx_q[$];
  int fstart = 0;

  task automatic send_byte(input logic [7:0] b, input int gmin, input int gmax);
    int g, tries;
    bit rdy;
    g = $urandom_range(gmax, gmin);
    repeat (g) begin in_valid = 1'b0; @(negedge clk); end
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    do begin
      rdy = in_ready;
      @(negedge clk);
      tries++;
    end while (!rdy && tries < 50);
    in_valid = 1'b0;
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout t=%0t got=in_ready_low exp=accept", $time);
    end
  endtask

  task automatic send_all(input int gmin, input int gmax);
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), gmin, gmax);
    repeat (4) @(negedge clk);
  endtask

  task automatic push_cs(input bit corrupt);
    int s;
    if (CS != 0) begin
      s = 0;
      for (int i = fstart + 1; i < tx_q.size(); i++) s += int'(tx_q[i]);
      tx_q.push_back(8'(-s) ^ {7'b0, corrupt});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic back-to-back frame
    fstart = tx_q.size();
    tx_q = {tx_q, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    push_cs(1'b0);
    send_all(0, 0);
    exp_q = {28'h0100011, 28'h0100122, 28'h0100233};
    check_obs("basic", 1, 0);

    // noise bytes then frame, valid toggling every other cycle
    tx_q = {8'h00, 8'hFF};
    fstart = tx_q.size();
    tx_q = {tx_q, 8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    push_cs(1'b0);
    send_all(1, 1);
    exp_q = {28'h0100011, 28'h0100122, 28'h0100233};
    check_obs("noise", 1, 0);

    // address wrap
    fstart = tx_q.size();
    tx_q = {tx_q, 8'hA5, 8'hFF, 8'hFF, 8'h0F, 8'h02, 8'h00, 8'hAA, 8'hBB};
    push_cs(1'b0);
    send_all(0, 1);
    exp_q = {28'hFFFFFAA, 28'h00000BB};
    check_obs("wrap", 1, 0);

    // out-of-range address byte
    tx_q = {8'hA5, 8'h00, 8'h00, 8'h1F};
    send_all(0, 0);
    check_obs("badaddr", 0, 1);

    // zero length
    fstart = tx_q.size();
    tx_q = {tx_q, 8'hA5, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
    push_cs(1'b0);
    send_all(0, 0);
    check_obs("zerolen", 1, 0);

    // reset after second payload byte of an N=4 frame
    tx_q = {8'hA5, 8'h00, 8'h20, 8'h00, 8'h04, 8'h00, 8'hC1, 8'hC2};
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_a", 32'(a), 32'd0);
    chk("rstmid_we", 32'(we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    exp_q = {28'h02000C1, 28'h02001C2};
    check_obs("rstmid", 0, 0);

    fstart = tx_q.size();
    tx_q = {tx_q, 8'hA5, 8'h00, 8'h30, 8'h00, 8'h01, 8'h00, 8'h5A};
    push_cs(1'b0);
    send_all(0, 0);
    exp_q = {28'h030005A};
    check_obs("fresh", 1, 0);

`ifdef RAM_LOADER_CHECKSUM_EN
    tx_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h05, 8'hFA};
    send_all(0, 0);
    exp_q = {28'h0000005};
    check_obs("csum_ok", 1, 0);

    tx_q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h05, 8'hFB};
    send_all(0, 0);
    exp_q = {28'h0000005};
    check_obs("csum_bad", 0, 1);
`endif

    // randomized frames with noise, bad addresses and corrupt checksums
    for (int f = 0; f < 30; f++) begin
      int nn, n, bad;
      logic [7:0] nb;
      nn = $urandom_range(0, 2);
      for (int i = 0; i < nn; i++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == HDR) nb = 8'h5A;
        tx_q.push_back(nb);
      end
      fstart = tx_q.size();
      tx_q.push_back(HDR);
      tx_q.push_back(8'($urandom_range(0, 255)));
      tx_q.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (bad != 0) begin
        tx_q.push_back(8'h10 | 8'($urandom_range(0, 255)));
      end else begin
        tx_q.push_back(8'($urandom_range(0, 15)));
        n = $urandom_range(0, 6);
        tx_q.push_back(8'(n));
        tx_q.push_back(8'h00);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
        push_cs(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end
      send_all(0, 2);
    end
    exp_q.delete(); obs_q.delete(); obs_done = 0; obs_err = 0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
